parameterized_gray_decoder: RTL and testbench

Receive-side counterpart of the team's Gray counter. Accepts a Gray-coded count from an asynchronous source (another clock domain's counter or a rotary encoder) and synchronizes it. Decodes the count to binary and classifies each sample as hold, +1, -1 or illegal. Tracks a lock state and counts decode errors so downstream logic can trust the count or discard it.

---
 rtl/parameterized_gray_pkg.sv | 26 ++
 rtl/parameterized_gray_decoder_if.sv | 25 ++
 rtl/gray_input_sync.sv | 23 ++
 rtl/parameterized_gray_decoder.sv | 125 ++++++++++++
 tb/tb_parameterized_gray_decoder.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/parameterized_gray_pkg.sv
// rtl/parameterized_gray_pkg.sv - shared Gray-code types and conversion helpers
package parameterized_gray_pkg;

    localparam int MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Callers zero-extend narrower codes; leading zeros decode to leading zeros.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/parameterized_gray_decoder_if.sv
// rtl/parameterized_gray_decoder_if.sv - control and result bundle of the Gray decoder
interface parameterized_gray_decoder_if #(
    parameter int WIDTH         = 4,
    parameter int ERR_CNT_WIDTH = 8
);
    logic                     enable;
    logic                     clear_err;
    logic [WIDTH-1:0]         gray_in;
    logic [WIDTH-1:0]         binary_out;
    logic                     locked;
    logic                     step_up;
    logic                     step_down;
    logic                     step_err;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    modport master (
        output enable, clear_err, gray_in,
        input  binary_out, locked, step_up, step_down, step_err, err_count
    );

    modport slave (
        input  enable, clear_err, gray_in,
        output binary_out, locked, step_up, step_down, step_err, err_count
    );
endinterface

// File: rtl/gray_input_sync.sv
// rtl/gray_input_sync.sv - multi-flop synchronizer for a Gray-coded vector
module gray_input_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Only one bit changes per Gray step, so per-bit capture stays coherent.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage <= {stage[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage[SYNC_STAGES-1];
endmodule

// File: rtl/parameterized_gray_decoder.sv
// rtl/parameterized_gray_decoder.sv - synchronizes, decodes and step-classifies a Gray count
module parameterized_gray_decoder
    import parameterized_gray_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    parameterized_gray_decoder_if.slave  bus
);
    localparam int FILL_W = $clog2(SYNC_STAGES);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH || SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_params
        $error("parameterized_gray_decoder: WIDTH or SYNC_STAGES out of range");
    end

    logic [WIDTH-1:0]         sync_g;
    logic [WIDTH-1:0]         dec;
    logic [WIDTH-1:0]         delta;
    state_t                   state_q, state_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic [WIDTH-1:0]         bin_q, bin_d;
    logic                     up_q, up_d;
    logic                     down_q, down_d;
    logic                     err_q, err_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

    gray_input_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.gray_in),
        .q   (sync_g)
    );

    assign dec   = WIDTH'(gray2bin(MAX_WIDTH'(sync_g)));
    assign delta = dec - bin_q;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        bin_d   = bin_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            // Wait until reset zeros have drained out of the synchronizer.
            FILL: begin
                if (fill_q == FILL_W'(SYNC_STAGES - 1)) begin
                    state_d = ACQUIRE;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
            ACQUIRE: begin
                if (bus.enable) begin
                    bin_d   = dec;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (bus.enable && delta != '0) begin
                    bin_d = dec;
                    if (delta == WIDTH'(1)) begin
                        up_d = 1'b1;
                    end else if (delta == '1) begin
                        down_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ACQUIRE;
                    end
                end
            end
            default: begin
                state_d = FILL;
                fill_d  = '0;
            end
        endcase
    end

    // A clear coinciding with a new error keeps that error counted.
    always_comb begin
        cnt_d = cnt_q;
        if (err_d) begin
            if (bus.clear_err) begin
                cnt_d = ERR_CNT_WIDTH'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (bus.clear_err) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            fill_q  <= '0;
            bin_q   <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            bin_q   <= bin_d;
            up_q    <= up_d;
            down_q  <= down_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.binary_out = bin_q;
    assign bus.locked     = (state_q == LOCKED);
    assign bus.step_up    = up_q;
    assign bus.step_down  = down_q;
    assign bus.step_err   = err_q;
    assign bus.err_count  = cnt_q;
endmodule

// File: tb/tb_parameterized_gray_decoder.sv
// tb/tb_parameterized_gray_decoder.sv - scoreboard bench for the Gray decoder
module tb_parameterized_gray_decoder;
    localparam int W    = 4;
    localparam int S    = 2;
    localparam int ECW  = 2;
    localparam int MOD  = 1 << W;
    localparam int CMAX = (1 << ECW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parameterized_gray_decoder_if #(.WIDTH(W), .ERR_CNT_WIDTH(ECW)) bus ();

    parameterized_gray_decoder #(
        .WIDTH         (W),
        .SYNC_STAGES   (S),
        .ERR_CNT_WIDTH (ECW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int bin;
        bit locked;
        bit up;
        bit down;
        bit err;
        int cnt;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    int   pipe[$];
    int   m_bin;
    int   m_cnt;
    bit   m_locked;
    int   since_rst;
    int   cur_g;

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b % MOD;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) % MOD;
    endfunction

    task automatic model_edge(input bit r, input bit e, input bit c, input int g);
        exp_t x;
        int   sg;
        int   dec;
        int   d;
        bit   up, down, er;
        up = 0; down = 0; er = 0;
        if (r) begin
            pipe = {};
            for (int i = 0; i < S; i++) pipe.push_back(0);
            m_bin = 0; m_cnt = 0; m_locked = 0; since_rst = 0;
        end else begin
            sg  = pipe[S-1];
            dec = g2b(sg);
            pipe.push_front(g);
            void'(pipe.pop_back());
            if (since_rst < S) begin
                since_rst++;
            end else if (e) begin
                if (!m_locked) begin
                    m_bin    = dec;
                    m_locked = 1;
                end else begin
                    d = (dec - m_bin + MOD) % MOD;
                    if (d == 1) up = 1;
                    else if (d == MOD - 1) down = 1;
                    else if (d != 0) begin
                        er       = 1;
                        m_locked = 0;
                    end
                    m_bin = dec;
                end
            end
            if (er) m_cnt = c ? 1 : (m_cnt < CMAX ? m_cnt + 1 : m_cnt);
            else if (c) m_cnt = 0;
        end
        x.bin = m_bin; x.locked = m_locked; x.up = up; x.down = down; x.err = er; x.cnt = m_cnt;
        expq.push_back(x);
    endtask

    task automatic cyc(input bit r, input bit e, input bit c, input int g);
        rst           = r;
        bus.enable    = e;
        bus.clear_err = c;
        bus.gray_in   = W'(g);
        @(posedge clk);
        model_edge(r, e, c, g);
        #2;
    endtask

    task automatic hold(input int g, input int n);
        cur_g = g;
        repeat (n) cyc(1'b0, 1'b1, 1'b0, g);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                x = expq.pop_front();
                chk("binary_out", 32'(bus.binary_out), x.bin);
                chk("locked",     32'(bus.locked),     int'(x.locked));
                chk("step_up",    32'(bus.step_up),    int'(x.up));
                chk("step_down",  32'(bus.step_down),  int'(x.down));
                chk("step_err",   32'(bus.step_err),   int'(x.err));
                chk("err_count",  32'(bus.err_count),  x.cnt);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, nb, cb;
        cur_g = 0;
        // reset, fill, acquire
        cyc(1'b1, 1'b1, 1'b0, 0);
        cyc(1'b1, 1'b1, 1'b0, 0);
        hold(0, 6);
        // up-count 0..4
        hold(1, 4); hold(3, 4); hold(2, 4); hold(6, 4);
        for (int b = 5; b < MOD; b++) hold(b2g(b), 2);
        // wrap both ways
        hold(0, 4); hold(8, 4); hold(0, 3);
        // illegal jump 1 -> 6
        hold(1, 4); hold(5, 6);
        // saturate error counter
        for (int k = 0; k < 5; k++) hold((k % 2 == 0) ? 0 : 5, 4);
        cyc(1'b0, 1'b1, 1'b1, 5);
        hold(5, 3);
        cyc(1'b0, 1'b1, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b1, 0);
        hold(0, 4);
        // disabled skip, re-enable, mid-stream reset
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 3);
        hold(3, 4);
        cyc(1'b1, 1'b1, 1'b0, 3);
        hold(3, 6);
        // randomized walk
        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 9);
            cb = g2b(cur_g);
            if (r < 4)      nb = (cb + 1) % MOD;
            else if (r < 7) nb = (cb + MOD - 1) % MOD;
            else if (r < 8) nb = cb;
            else            nb = $urandom_range(0, MOD - 1);
            cur_g = b2g(nb);
            repeat ($urandom_range(1, 4))
                cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 19) == 0, cur_g);
        end
        hold(cur_g, 3);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
